// File: rtl/magnitude_trend_monitor_pkg.sv
// Shared definitions for the magnitude trend monitor: FSM state encoding
// and the width of the consecutive-sample run counter.
package magnitude_trend_monitor_pkg;

  localparam int RUN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_ALARM     = 2'd2,
    ST_RELEASING = 2'd3
  } state_t;

endpackage

// File: rtl/magnitude_trend_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead
// of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/magnitude_trend_monitor.sv
// Tallies comparator EQ/G/L outcomes and runs a hysteresis FSM that raises
// ALARM on a sustained A>B trend and drops it on a sustained A<B trend.
module magnitude_trend_monitor
  import magnitude_trend_monitor_pkg::*;
#(
  parameter int HOLD_CNT = 3,
  parameter int REL_CNT  = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             VALID,
  input  logic             EQ,
  input  logic             G,
  input  logic             L,
  input  logic             CLR,
  output logic             ALARM,
  output logic             ALARM_SET,
  output logic             ALARM_CLR,
  output logic [CNT_W-1:0] G_CNT,
  output logic [CNT_W-1:0] L_CNT,
  output logic [CNT_W-1:0] EQ_CNT,
  output logic             ERR,
  output logic [1:0]       STATE
);

  localparam logic [RUN_W-1:0] HOLD_RUN = RUN_W'(HOLD_CNT);
  localparam logic [RUN_W-1:0] REL_RUN  = RUN_W'(REL_CNT);

  logic one_hot;
  logic sample_ok;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic             alarm_q, alarm_d;
  logic             set_q, set_d;
  logic             clr_q, clr_d;
  logic             err_q;

  assign one_hot   = $onehot({EQ, G, L});
  // CLR outranks VALID, so a sample in a clearing cycle is dropped entirely.
  assign sample_ok = VALID && one_hot && !CLR;
  assign run_inc   = run_q + 1'b1;

  sat_counter #(.W(CNT_W)) u_g_cnt (
    .clk(clk), .rst_n(rst_n), .clr(CLR), .inc(sample_ok && G), .q(G_CNT)
  );

  sat_counter #(.W(CNT_W)) u_l_cnt (
    .clk(clk), .rst_n(rst_n), .clr(CLR), .inc(sample_ok && L), .q(L_CNT)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk(clk), .rst_n(rst_n), .clr(CLR), .inc(sample_ok && EQ), .q(EQ_CNT)
  );

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (CLR) begin
      state_d = ST_IDLE;
      run_d   = '0;
    end else if (sample_ok) begin
      unique case (state_q)
        ST_IDLE: begin
          if (G) begin
            state_d = (HOLD_CNT == 1) ? ST_ALARM : ST_ARMING;
            run_d   = (HOLD_CNT == 1) ? '0 : RUN_W'(1);
          end
        end
        ST_ARMING: begin
          if (G) begin
            state_d = (run_inc == HOLD_RUN) ? ST_ALARM : ST_ARMING;
            run_d   = (run_inc == HOLD_RUN) ? '0 : run_inc;
          end else begin
            state_d = ST_IDLE;
            run_d   = '0;
          end
        end
        ST_ALARM: begin
          if (L) begin
            state_d = (REL_CNT == 1) ? ST_IDLE : ST_RELEASING;
            run_d   = (REL_CNT == 1) ? '0 : RUN_W'(1);
          end
        end
        ST_RELEASING: begin
          if (L) begin
            state_d = (run_inc == REL_RUN) ? ST_IDLE : ST_RELEASING;
            run_d   = (run_inc == REL_RUN) ? '0 : run_inc;
          end else if (G) begin
            state_d = ST_ALARM;
            run_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      endcase
    end

    alarm_d = (state_d == ST_ALARM) || (state_d == ST_RELEASING);
    // RELEASING->ALARM is excluded: ALARM never dropped, so there is no rise.
    set_d   = !CLR && ((state_q == ST_IDLE) || (state_q == ST_ARMING))
              && (state_d == ST_ALARM);
    clr_d   = !CLR && ((state_q == ST_ALARM) || (state_q == ST_RELEASING))
              && (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      alarm_q <= 1'b0;
      set_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      alarm_q <= alarm_d;
      set_q   <= set_d;
      clr_q   <= clr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (CLR) begin
      err_q <= 1'b0;
    end else if (VALID && !one_hot) begin
      err_q <= 1'b1;
    end
  end

  assign ALARM     = alarm_q;
  assign ALARM_SET = set_q;
  assign ALARM_CLR = clr_q;
  assign ERR       = err_q;
  assign STATE     = state_q;

endmodule

// File: doc/magnitude_trend_monitor.md
Name: magnitude_trend_monitor

Overview:
Downstream consumer of the 4-bit magnitude comparator's EQ/G/L result flags. Samples one result per VALID cycle and keeps saturating tallies of each outcome. A hysteresis FSM raises ALARM after HOLD_CNT consecutive A>B samples and drops it after REL_CNT consecutive A<B samples. It also flags malformed (non-one-hot) comparator results.

Parameters:
HOLD_CNT, 3, consecutive valid G samples needed to assert ALARM (legal range 1..15)
REL_CNT, 2, consecutive valid L samples needed to release ALARM (legal range 1..15)
CNT_W, 8, width of each saturating outcome counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
VALID  input  1  EQ/G/L carry a new sample this cycle
EQ  input  1  comparator A=B
G  input  1  comparator A>B
L  input  1  comparator A<B
CLR  input  1  synchronous clear of counters, ERR and FSM
ALARM  output  1  registered; high in states ALARM and RELEASING
ALARM_SET  output  1  one-cycle pulse when ALARM rises
ALARM_CLR  output  1  one-cycle pulse when ALARM falls through release
G_CNT  output  CNT_W  saturating count of valid G samples
L_CNT  output  CNT_W  saturating count of valid L samples
EQ_CNT  output  CNT_W  saturating count of valid EQ samples
ERR  output  1  sticky; set by a valid sample that is not one-hot
STATE  output  2  FSM state: IDLE=0, ARMING=1, ALARM=2, RELEASING=3

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, STATE=IDLE, run counter 0. Reset asserted mid-run discards the run.
- Every output is registered. A sample on edge N is reflected in the outputs after edge N, with no additional latency.
- VALID=0: nothing changes, and the run counter holds. Gaps between samples therefore do not break a run.
- Valid sample that is not one-hot (zero or more than one of EQ/G/L set): ERR<=1. Counters, FSM and run counter are unchanged.
- Valid one-hot sample: the matching counter increments and saturates at 2^CNT_W-1 with no wrap.
- FSM transitions on valid one-hot samples. The run counter is 4 bits.
  - IDLE: G -> ARMING with run=1, or directly to ALARM when HOLD_CNT=1. L or EQ -> stay in IDLE.
  - ARMING: G -> run+1, moving to ALARM when run+1 = HOLD_CNT. L or EQ -> IDLE, run=0.
  - ALARM: L -> RELEASING with run=1, or directly to IDLE when REL_CNT=1. G or EQ -> stay in ALARM.
  - RELEASING: L -> run+1, moving to IDLE when run+1 = REL_CNT. G -> ALARM, run=0. EQ -> hold state and run.
- ALARM_SET pulses for exactly one cycle on entry to ALARM from IDLE or ARMING. A RELEASING->ALARM return produces no pulse, because ALARM never fell.
- ALARM_CLR pulses for exactly one cycle on the transition into IDLE from ALARM or RELEASING.
- CLR (synchronous, priority over VALID in the same cycle) zeroes the counters, ERR, the run counter and both pulses, and forces STATE=IDLE and ALARM=0. CLR never produces an ALARM_CLR pulse.
- Both pulses are 0 in every cycle that has no qualifying transition.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_ARMING, ST_ALARM, ST_RELEASING) and the RUN_W=4 constant.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, clr, inc, q), instantiated three times for G_CNT, L_CNT and EQ_CNT.
- The FSM, run counter and pulse generation stay in the top module.

Test Plan:
1. Defaults. VALID G,G,G on consecutive cycles -> ALARM=1 and ALARM_SET=1 after the third edge; ALARM_SET=0 the next cycle; G_CNT=3, STATE=2.
2. G, G, L -> ALARM stays 0, STATE returns to 0, G_CNT=2, L_CNT=1. Then G, VALID=0 for 5 cycles, G, G -> ALARM asserts, because the gap holds the run.
3. From ALARM, drive L, EQ, L -> STATE goes 3, 3, 0; ALARM_CLR pulses one cycle after the second L. Separately, from ALARM drive L, G -> STATE goes 3 then 2 with no ALARM_SET pulse.
4. CNT_W=4, 20 valid EQ samples -> EQ_CNT=15 and stays at 15; other counters 0; STATE=0.
5. Valid EQ=1,G=1, then valid 0,0,0 -> ERR=1, all counters and STATE unchanged. Then CLR=1 with VALID=1,G=1 in the same cycle -> ERR=0, counters 0, STATE=0, G not counted.
6. Drive G,G (STATE=1), then pulse rst_n low asynchronously between edges -> all outputs 0 immediately. After release, G,G,G -> ALARM asserts on the third sample, not earlier.
